// File: rtl/riscv_csr_state.sv
// Machine-mode CSR state: combinational read port, edge-committed writes, counters, trap/mret, irq decision.
// Latency: reads and illegal flag are zero-cycle combinational; writes and trap/mret updates are visible next cycle.
// Backpressure: ex_stall blocks the write commit only; trap, mret and counter updates are never stalled.

package riscv_pkg;
    localparam logic [1:0] MXL_RV32 = 2'b01;
endpackage

module riscv_csr_state #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned HAS_RVC    = 0,
    parameter logic [31:0] HARTID     = 32'd0,
    parameter logic [31:0] MTVEC_INIT = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_stall,
    input  logic [11:0]     ex_csr_reg,
    input  logic            ex_csr_we,
    input  logic [XLEN-1:0] ex_csr_wval,
    output logic [XLEN-1:0] st_csr_rval,
    output logic [1:0]      st_xlen,
    output logic            st_csr_illegal,
    input  logic            wb_retire,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_req,
    input  logic            ext_irq,
    input  logic            tmr_irq,
    input  logic            sw_irq,
    output logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] mret_pc,
    output logic            irq_req
);
    localparam logic [XLEN-1:0] MISA_VAL   = 32'h4000_0100 | ((HAS_RVC != 0) ? 32'h4 : 32'h0);
    localparam logic [XLEN-1:0] MEPC_MASK  = (HAS_RVC != 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;
    localparam logic [XLEN-1:0] MTVEC_MASK = 32'hFFFF_FFFD;

    logic            mstatus_mie_q, mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic            mie_msie_q, mie_msie_d;
    logic            mie_mtie_q, mie_mtie_d;
    logic            mie_meie_q, mie_meie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [2*XLEN-1:0] mcycle_q, mcycle_d;
    logic [2*XLEN-1:0] minstret_q, minstret_d;

    logic            implemented;
    logic            read_only;
    logic            csr_wr;
    logic [XLEN-1:0] mip_val;
    logic [XLEN-1:0] tvec_base;

    assign mip_val = {{(XLEN-12){1'b0}}, ext_irq, 3'b000, tmr_irq, 3'b000, sw_irq, 3'b000};

    // Address decode: read data, implemented/read-only classification.
    always_comb begin
        st_csr_rval = '0;
        implemented = 1'b1;
        read_only   = 1'b0;
        case (ex_csr_reg)
            12'hF11, 12'hF12, 12'hF13: read_only = 1'b1;
            12'hF14: begin
                st_csr_rval = HARTID;
                read_only   = 1'b1;
            end
            12'h301: st_csr_rval = MISA_VAL;
            12'h300: begin
                st_csr_rval[12:11] = 2'b11;
                st_csr_rval[7]     = mstatus_mpie_q;
                st_csr_rval[3]     = mstatus_mie_q;
            end
            12'h304: begin
                st_csr_rval[11] = mie_meie_q;
                st_csr_rval[7]  = mie_mtie_q;
                st_csr_rval[3]  = mie_msie_q;
            end
            12'h344: st_csr_rval = mip_val;
            12'h305: st_csr_rval = mtvec_q;
            12'h340: st_csr_rval = mscratch_q;
            12'h341: st_csr_rval = mepc_q;
            12'h342: st_csr_rval = mcause_q;
            12'h343: st_csr_rval = mtval_q;
            12'hB00: st_csr_rval = mcycle_q[XLEN-1:0];
            12'hB80: st_csr_rval = mcycle_q[2*XLEN-1:XLEN];
            12'hB02: st_csr_rval = minstret_q[XLEN-1:0];
            12'hB82: st_csr_rval = minstret_q[2*XLEN-1:XLEN];
            12'hC00: begin
                st_csr_rval = mcycle_q[XLEN-1:0];
                read_only   = 1'b1;
            end
            12'hC80: begin
                st_csr_rval = mcycle_q[2*XLEN-1:XLEN];
                read_only   = 1'b1;
            end
            12'hC02: begin
                st_csr_rval = minstret_q[XLEN-1:0];
                read_only   = 1'b1;
            end
            12'hC82: begin
                st_csr_rval = minstret_q[2*XLEN-1:XLEN];
                read_only   = 1'b1;
            end
            default: implemented = 1'b0;
        endcase
    end

    assign st_csr_illegal = !implemented || (ex_csr_we && read_only);
    assign st_xlen        = riscv_pkg::MXL_RV32;
    // Trap and mret both squash a same-cycle CSR write.
    assign csr_wr         = ex_csr_we && !ex_stall && !st_csr_illegal && !trap_req && !mret_req;

    assign tvec_base   = {mtvec_q[XLEN-1:2], 2'b00};
    assign trap_vector = (mtvec_q[0] && trap_cause[XLEN-1])
                         ? tvec_base + {{(XLEN-6){1'b0}}, trap_cause[3:0], 2'b00}
                         : tvec_base;
    assign mret_pc     = mepc_q;
    assign irq_req     = mstatus_mie_q && ((mie_msie_q && sw_irq) || (mie_mtie_q && tmr_irq)
                                           || (mie_meie_q && ext_irq));

    // Next-state: counters free-run, then trap > mret > CSR write; a counter write replaces its increment.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_msie_d     = mie_msie_q;
        mie_mtie_d     = mie_mtie_q;
        mie_meie_d     = mie_meie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        mcycle_d       = mcycle_q + 1'b1;
        minstret_d     = minstret_q + {{(2*XLEN-1){1'b0}}, wb_retire};
        if (trap_req) begin
            mepc_d         = trap_pc & MEPC_MASK;
            mcause_d       = trap_cause;
            mtval_d        = trap_tval;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_req) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (csr_wr) begin
            case (ex_csr_reg)
                12'h300: begin
                    mstatus_mie_d  = ex_csr_wval[3];
                    mstatus_mpie_d = ex_csr_wval[7];
                end
                12'h304: begin
                    mie_msie_d = ex_csr_wval[3];
                    mie_mtie_d = ex_csr_wval[7];
                    mie_meie_d = ex_csr_wval[11];
                end
                12'h305: mtvec_d    = ex_csr_wval & MTVEC_MASK;
                12'h340: mscratch_d = ex_csr_wval;
                12'h341: mepc_d     = ex_csr_wval & MEPC_MASK;
                12'h342: mcause_d   = ex_csr_wval;
                12'h343: mtval_d    = ex_csr_wval;
                12'hB00: mcycle_d   = {mcycle_q[2*XLEN-1:XLEN], ex_csr_wval};
                12'hB80: mcycle_d   = {ex_csr_wval, mcycle_q[XLEN-1:0]};
                12'hB02: minstret_d = {minstret_q[2*XLEN-1:XLEN], ex_csr_wval};
                12'hB82: minstret_d = {ex_csr_wval, minstret_q[XLEN-1:0]};
                default: ;
            endcase
        end
    end

    // State registers with synchronous reset overriding every other update.
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_msie_q     <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mie_meie_q     <= 1'b0;
            mtvec_q        <= MTVEC_INIT & MTVEC_MASK;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            mcycle_q       <= '0;
            minstret_q     <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_msie_q     <= mie_msie_d;
            mie_mtie_q     <= mie_mtie_d;
            mie_meie_q     <= mie_meie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
        end
    end
endmodule

// File: doc/riscv_csr_state.md
# riscv_csr_state

Machine-mode CSR state unit for the RV32 core: the responder on the execute stage's CSR access port. It returns the addressed CSR value combinationally in the same cycle and commits execute-stage writes at the clock edge. It also owns the cycle/instret counters, trap entry and `mret` state updates, and the interrupt-pending decision.

## Interface
- `XLEN`, 32: data width; only 32 is supported.
- `HAS_RVC`, 0: compressed-ISA support; sets `misa.C` and the `mepc` alignment rule.
- `HARTID`, 0: value returned by `mhartid`.
- `MTVEC_INIT`, 32'h0000_0100: reset value of `mtvec`.

Ports:
- `clk` input 1: clock.
- `rst` input 1: synchronous, active-high reset.
- `ex_stall` input 1: execute stage stalled; blocks CSR writes.
- `ex_csr_reg` input 12: CSR address.
- `ex_csr_we` input 1: CSR write request.
- `ex_csr_wval` input XLEN: CSR write data.
- `st_csr_rval` output XLEN: read data for `ex_csr_reg`, combinational.
- `st_xlen` output 2: constant RV32I encoding from `riscv_pkg`.
- `st_csr_illegal` output 1: `ex_csr_reg` is unimplemented, or `ex_csr_we` targets a read-only CSR. Combinational.
- `wb_retire` input 1: one instruction retired this cycle.
- `trap_req` input 1: take a trap.
- `trap_cause` input XLEN: value written to `mcause`.
- `trap_pc` input XLEN: value written to `mepc`.
- `trap_tval` input XLEN: value written to `mtval`.
- `mret_req` input 1: execute `mret`.
- `ext_irq`, `tmr_irq`, `sw_irq` input 1 each: level interrupt lines.
- `trap_vector` output XLEN: handler address, combinational.
- `mret_pc` output XLEN: current `mepc`.
- `irq_req` output 1: interrupt pending and enabled, combinational.

## Operation
CSR map and behaviour:
- **Read-only ID registers.** 0xF11–0xF13 read 0. 0xF14 reads `HARTID`. 0x301 `misa` reads 32'h4000_0100, with bit 2 set when `HAS_RVC` is nonzero; writes to `misa` are ignored, with no illegal flag.
- **0x300 `mstatus`.** MIE (bit 3) and MPIE (bit 7) are writable. MPP (bits 12:11) always reads 2'b11. All other bits read 0.
- **0x304 `mie`.** Bits 3, 7 and 11 are writable; all other bits read 0.
- **0x344 `mip`.** MSIP (bit 3) = `sw_irq`, MTIP (bit 7) = `tmr_irq`, MEIP (bit 11) = `ext_irq`, sampled live. Writes are ignored.
- **0x305 `mtvec`.** Bits 31:2 and bit 0 are writable; bit 1 reads 0. Mode is 0 (direct) or 1 (vectored).
- **0x340 `mscratch`, 0x342 `mcause`, 0x343 `mtval`.** Fully writable.
- **0x341 `mepc`.** Bit 0 always reads 0. Bit 1 is also forced to 0 when `HAS_RVC`=0.
- **0xB00/0xB80 `mcycle`/`mcycleh`, 0xB02/0xB82 `minstret`/`minstreth`.** These are the low/high halves of 64-bit counters and are writable.
- **0xC00, 0xC02, 0xC80, 0xC82.** Read-only shadows of the four counter halves. A write attempt raises `st_csr_illegal` and is discarded.
- **Any other address.** Reads 0 and raises `st_csr_illegal`.

Sequential updates, per cycle, in priority order:
1. `rst`:
   - All CSRs return to reset values: `mstatus` MIE/MPIE = 0; `mie` = 0; `mtvec` = `MTVEC_INIT`; everything else = 0.
   - No other action is taken.
2. `trap_req`:
   - `mepc`, `mcause` and `mtval` load `trap_pc`, `trap_cause` and `trap_tval`; `mepc` applies its alignment masking.
   - MPIE ← MIE, then MIE ← 0.
   - Any CSR write in the same cycle is discarded.
   - `mret_req` is ignored.
3. `mret_req`:
   - MIE ← MPIE, then MPIE ← 1.
   - A same-cycle CSR write is discarded.
4. CSR write:
   - Commits when `ex_csr_we` & !`ex_stall` & !`st_csr_illegal`.
   - The WARL masks above are applied.

Counters:
- `mcycle` increments every cycle that is not in reset.
- `minstret` increments when `wb_retire` = 1.
- A carry out of the low word increments the high word. 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
- In a cycle where either half of a counter is written, the written half takes the write value and that whole counter does not increment.

Trap vector and interrupts:
- `trap_vector` = {`mtvec`[31:2], 2'b00}.
- In vectored mode, when `trap_cause`[31] = 1, `trap_vector` = that base + 4·`trap_cause`[3:0].
- `irq_req` = `mstatus`.MIE & |(`mie` & `mip`).

## Timing
- The read path `ex_csr_reg` → `st_csr_rval` is zero-latency combinational.
- A written value is readable from the next cycle.
- Counter reads return the pre-edge value: a read in cycle N shows the count before cycle N's increment.
- `trap_vector`, `mret_pc` and `irq_req` reflect register state as of the previous edge.
- A trap taken at edge N makes MIE = 0, and therefore `irq_req` = 0, from cycle N+1.
- Output values during and after reset:
  - `st_csr_rval` shows the addressed CSR's reset value.
  - `irq_req` = 0.
  - `mret_pc` = 0.
  - `trap_vector` = `MTVEC_INIT` with bits 1:0 cleared.
- Reset asserted in the middle of an operation overrides any concurrent trap, `mret` or write in that cycle.

## Test plan
- Reset, then write `mscratch` = 32'hDEAD_BEEF → reads back 32'hDEAD_BEEF the next cycle. Repeat the write with `ex_stall` = 1 → value unchanged.
- Write 32'hFFFF_FFFF to `mstatus`, `mie` and `mtvec` → reads 32'h0000_1888, 32'h0000_0888 and 32'hFFFF_FFFD respectively.
- Write `mcycle` = 32'hFFFF_FFFE and `mcycleh` = 0, then let two cycles pass → {`mcycleh`, `mcycle`} = 64'h1_0000_0000. Write address 0xC00 → `st_csr_illegal` = 1 and the value is unchanged.
- Set `mtvec` = 32'h201 and MIE = 1, then `trap_req` with `trap_cause` = 32'h8000_0007, `trap_pc` = 32'h1236:
  - `trap_vector` = 32'h21C during the `trap_req` cycle.
  - Next cycle: `mepc` = 32'h1234, MPIE = 1, MIE = 0.
  - `mret_req` then gives MIE = 1, MPIE = 1.
- With `mie`.MTIE = 1 and MIE = 1, assert `tmr_irq` → `irq_req` = 1 in the same cycle. Clear MIE → `irq_req` = 0. Write `mip` → value unchanged.
- Assert `trap_req` and a CSR write to `mcause` in the same cycle → `mcause` = `trap_cause`. Assert `rst` together with `trap_req` → all CSRs take reset values.
